// File: rtl/blob_pkg.sv
// Shared encodings for the blob centroid tracker: colour modes, FSM states and marker colour.
package blob_pkg;

    localparam logic [1:0] MODE_LUMA  = 2'd0;
    localparam logic [1:0] MODE_RED   = 2'd1;
    localparam logic [1:0] MODE_GREEN = 2'd2;
    localparam logic [1:0] MODE_BLUE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_X  = 2'd1,
        ST_DIV_Y  = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    localparam logic [23:0] MARK_DEFAULT = 24'h00FF00;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. nbits selects how many low dividend bits
// take part, so the same instance can serve dividends of different widths. done is high
// during the last step and quotient carries that step's result combinationally.
module seq_divider #(
    parameter int W    = 29,
    parameter int DW   = 19,
    parameter int QW   = 10,
    parameter int CNTW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    dividend,
    input  logic [DW-1:0]   divisor,
    input  logic [CNTW-1:0] nbits,
    output logic            done,
    output logic [QW-1:0]   quotient
);

    logic [DW:0]     rem_q, rem_d, rem_step_s;
    logic [W-1:0]    quo_q, quo_d, quo_step_s;
    logic [DW+1:0]   shifted_s, diff_s;
    logic [CNTW-1:0] cnt_q, cnt_d, shamt_s;

    assign shamt_s  = CNTW'(W) - nbits;
    assign done     = (cnt_q == CNTW'(1));
    assign quotient = quo_step_s[QW-1:0];

    // One restoring step: shift in the next dividend bit and subtract if it fits
    always_comb begin
        shifted_s = {rem_q, quo_q[W-1]};
        diff_s    = shifted_s - {2'b00, divisor};
        if (diff_s[DW+1]) begin
            rem_step_s = shifted_s[DW:0];
            quo_step_s = {quo_q[W-2:0], 1'b0};
        end else begin
            rem_step_s = diff_s[DW:0];
            quo_step_s = {quo_q[W-2:0], 1'b1};
        end
    end

    // Load on start (dividend left-aligned), otherwise iterate until the count runs out
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend << shamt_s;
            cnt_d = nbits;
        end else if (cnt_q != '0) begin
            rem_d = rem_step_s;
            quo_d = quo_step_s;
            cnt_d = cnt_q - CNTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers; reset aborts any running division
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blob_centroid_tracker.sv
// Colour-blob tracker: classifies pixels, accumulates hit coordinates per frame, divides at
// frame end to find the centroid and overlays a crosshair on the outgoing video.
module blob_centroid_tracker
    import blob_pkg::*;
#(
    parameter int CW       = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int NW       = 19,
    parameter int ARM      = 8,
    parameter logic [3*CW-1:0] MARK_RGB = (3*CW)'(MARK_DEFAULT)
) (
    input  logic            ball_clock,
    input  logic            reset,
    input  logic [3*CW-1:0] video_in,
    input  logic            h_sync,
    input  logic            v_sync,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   threshold,
    input  logic [NW-1:0]   min_count,
    input  logic            overlay_en,
    input  logic            vid_select,
    output logic [3*CW-1:0] video_out,
    output logic            de_out,
    output logic [XW-1:0]   center_x,
    output logic [YW-1:0]   center_y,
    output logic            obj_present,
    output logic            center_valid,
    output logic            busy
);

    localparam int SXW  = XW + NW;
    localparam int SYW  = YW + NW;
    localparam int CNTW = $clog2(SXW + 1);

    logic            de_s, h_fall_s, v_rise_s, frame_end_s, hit_s, acc_en_s, cross_s;
    logic            skip_s, div_start_s, div_done_s;
    logic [CW-1:0]   r_s, g_s, b_s;
    logic [CW+1:0]   luma_s;
    logic [XW-1:0]   dx_s, quot_s;
    logic [YW-1:0]   dy_s;
    logic [NW-1:0]   min_eff_s;
    logic [SXW-1:0]  dividend_s;
    logic [CNTW-1:0] nbits_s;

    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            h_sync_q, h_sync_d, v_sync_q, v_sync_d, armed_q, armed_d;
    logic [SXW-1:0]  sum_x_q, sum_x_d;
    logic [SYW-1:0]  sum_y_q, sum_y_d;
    logic [NW-1:0]   n_q, n_d;
    logic [3*CW-1:0] video_q, video_d;
    logic            de_q, de_d;

    state_e          state_q;
    logic [SYW-1:0]  sum_y_snap_q;
    logic [NW-1:0]   n_snap_q;
    logic [XW-1:0]   cx_div_q, center_x_q;
    logic [YW-1:0]   cy_div_q, center_y_q;
    logic            obj_q, cv_q, busy_q;

    assign de_s        = h_sync & v_sync;
    assign h_fall_s    = h_sync_q & ~h_sync;
    assign v_rise_s    = ~v_sync_q & v_sync;
    assign frame_end_s = v_sync_q & ~v_sync & armed_q;

    // Sync edge history, pixel coordinates and the post-reset arming flag
    always_comb begin
        h_sync_d = h_sync;
        v_sync_d = v_sync;
        armed_d  = armed_q | v_rise_s;
        if (!h_sync) begin
            x_d = '0;
        end else if (de_s) begin
            x_d = x_q + XW'(1);
        end else begin
            x_d = x_q;
        end
        if (!v_sync) begin
            y_d = '0;
        end else if (h_fall_s) begin
            y_d = y_q + YW'(1);
        end else begin
            y_d = y_q;
        end
    end

    // Pixel classifier against the live mode and threshold
    always_comb begin
        r_s    = video_in[3*CW-1:2*CW];
        g_s    = video_in[2*CW-1:CW];
        b_s    = video_in[CW-1:0];
        luma_s = ({2'b00, r_s} + {1'b0, g_s, 1'b0} + {2'b00, b_s}) >> 2'd2;
        case (mode)
            MODE_LUMA:  hit_s = (luma_s >= {2'b00, threshold});
            MODE_RED:   hit_s = (r_s >= threshold) && (r_s > g_s) && (r_s > b_s);
            MODE_GREEN: hit_s = (g_s >= threshold) && (g_s > r_s) && (g_s > b_s);
            MODE_BLUE:  hit_s = (b_s >= threshold) && (b_s > r_s) && (b_s > g_s);
            default:    hit_s = 1'b0;
        endcase
    end

    // Per-frame accumulators; frame end clears them in the same cycle it snapshots them
    always_comb begin
        acc_en_s = de_s & (armed_q | v_rise_s) & hit_s
                   & (int'(x_q) < H_ACTIVE) & (int'(y_q) < V_ACTIVE);
        if (frame_end_s) begin
            sum_x_d = '0;
            sum_y_d = '0;
            n_d     = '0;
        end else if (acc_en_s) begin
            sum_x_d = sum_x_q + SXW'(x_q);
            sum_y_d = sum_y_q + SYW'(y_q);
            n_d     = n_q + NW'(1);
        end else begin
            sum_x_d = sum_x_q;
            sum_y_d = sum_y_q;
            n_d     = n_q;
        end
    end

    // Output pixel: mask or camera, crosshair overlay, blanked outside the active area
    always_comb begin
        dx_s    = (x_q >= center_x_q) ? (x_q - center_x_q) : (center_x_q - x_q);
        dy_s    = (y_q >= center_y_q) ? (y_q - center_y_q) : (center_y_q - y_q);
        cross_s = ((x_q == center_x_q) && (int'(dy_s) <= ARM)) ||
                  ((y_q == center_y_q) && (int'(dx_s) <= ARM));
        de_d    = de_s;
        if (!de_s) begin
            video_d = '0;
        end else if (overlay_en && obj_q && cross_s) begin
            video_d = MARK_RGB;
        end else if (vid_select) begin
            video_d = {(3*CW){hit_s}};
        end else begin
            video_d = video_in;
        end
    end

    // Datapath registers
    always_ff @(posedge ball_clock) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            h_sync_q <= 1'b0;
            v_sync_q <= 1'b1;
            armed_q  <= 1'b0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            n_q      <= '0;
            video_q  <= '0;
            de_q     <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            armed_q  <= armed_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            n_q      <= n_d;
            video_q  <= video_d;
            de_q     <= de_d;
        end
    end

    // Divider control: X division starts at frame end, Y division chains off X completion
    always_comb begin
        min_eff_s   = (min_count == '0) ? NW'(1) : min_count;
        skip_s      = (n_q < min_eff_s);
        div_start_s = ((state_q == ST_IDLE) && frame_end_s && !skip_s) ||
                      ((state_q == ST_DIV_X) && div_done_s);
        if (state_q == ST_IDLE) begin
            dividend_s = sum_x_q;
            nbits_s    = CNTW'(SXW);
        end else begin
            dividend_s = SXW'(sum_y_snap_q);
            nbits_s    = CNTW'(SYW);
        end
    end

    seq_divider #(
        .W    (SXW),
        .DW   (NW),
        .QW   (XW),
        .CNTW (CNTW)
    ) u_div (
        .clk      (ball_clock),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (n_snap_q),
        .nbits    (nbits_s),
        .done     (div_done_s),
        .quotient (quot_s)
    );

    // Centroid FSM with registered report outputs; frame ends while not idle are dropped
    always_ff @(posedge ball_clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sum_y_snap_q <= '0;
            n_snap_q     <= '0;
            cx_div_q     <= '0;
            cy_div_q     <= '0;
            center_x_q   <= '0;
            center_y_q   <= '0;
            obj_q        <= 1'b0;
            cv_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_end_s && skip_s) begin
                        cv_q  <= 1'b1;
                        obj_q <= 1'b0;
                    end else if (frame_end_s) begin
                        sum_y_snap_q <= sum_y_q;
                        n_snap_q     <= n_q;
                        busy_q       <= 1'b1;
                        state_q      <= ST_DIV_X;
                    end
                end
                ST_DIV_X: begin
                    if (div_done_s) begin
                        cx_div_q <= quot_s;
                        state_q  <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done_s) begin
                        cy_div_q <= (|quot_s[XW-1:YW]) ? '1 : quot_s[YW-1:0];
                        busy_q   <= 1'b0;
                        state_q  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    center_x_q <= cx_div_q;
                    center_y_q <= cy_div_q;
                    obj_q      <= 1'b1;
                    cv_q       <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign video_out    = video_q;
    assign de_out       = de_q;
    assign center_x     = center_x_q;
    assign center_y     = center_y_q;
    assign obj_present  = obj_q;
    assign center_valid = cv_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Directed bench for blob_centroid_tracker on a reduced 112x56 raster.
module tb_blob_centroid_tracker;

    localparam int CW = 8;
    localparam int H  = 112;
    localparam int V  = 56;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int NW = 19;
    localparam int HB = 4;
    localparam int LAT_MAX = XW + YW + 2 * NW + 2;
    localparam logic [23:0] MARK = 24'h00FF00;

    logic          ball_clock = 1'b0;
    logic          reset;
    logic [23:0]   video_in;
    logic          h_sync, v_sync;
    logic [1:0]    mode;
    logic [7:0]    threshold;
    logic [NW-1:0] min_count;
    logic          overlay_en, vid_select;
    logic [23:0]   video_out;
    logic          de_out;
    logic [XW-1:0] center_x;
    logic [YW-1:0] center_y;
    logic          obj_present, center_valid, busy;

    int errors = 0;
    int checks = 0;
    int cv_total = 0;
    int lat, c0;
    bit busy_seen;
    logic [23:0] out_mem [0:V-1][0:H-1];

    blob_centroid_tracker #(
        .CW(CW), .H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .NW(NW), .ARM(8)
    ) dut (
        .ball_clock   (ball_clock),
        .reset        (reset),
        .video_in     (video_in),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .mode         (mode),
        .threshold    (threshold),
        .min_count    (min_count),
        .overlay_en   (overlay_en),
        .vid_select   (vid_select),
        .video_out    (video_out),
        .de_out       (de_out),
        .center_x     (center_x),
        .center_y     (center_y),
        .obj_present  (obj_present),
        .center_valid (center_valid),
        .busy         (busy)
    );

    always #5 ball_clock = ~ball_clock;

    always @(negedge ball_clock) begin
        if (center_valid) cv_total++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ball_clock);
        #1;
    endtask

    function automatic logic [23:0] pix(input int pat, input int x, input int y);
        logic [23:0] p;
        p = 24'h000000;
        case (pat)
            0: begin
                if (x >= 100 && x <= 103 && y >= 50 && y <= 53) p = 24'hC81414;
                else if (x == 10 && y == 10) p = 24'hC8C800;
                else if (x == 20 && y == 20) p = 24'h780000;
                else if (x == 30 && y == 30) p = 24'h0000FF;
                else p = 24'h000000;
            end
            1: if (x == 0 && y == 0) p = 24'hFF0000;
            3: begin
                if (x == H - 1 && y == V - 1) p = 24'hD2D2D2;
                else if (x == 5 && y == 5) p = 24'hC6C6C6;
                else p = 24'h000000;
            end
            default: p = 24'h000000;
        endcase
        return p;
    endfunction

    // Drives one frame; reset is held high during lines below rst_lines
    task automatic run_frame(input int pat, input int rst_lines);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H + HB; x++) begin
                reset    = (y < rst_lines);
                v_sync   = 1'b1;
                h_sync   = (x < H);
                video_in = (x < H) ? pix(pat, x, y) : 24'h000000;
                tick();
                if (x < H) out_mem[y][x] = video_out;
            end
        end
        reset    = 1'b0;
        h_sync   = 1'b0;
        video_in = 24'h000000;
    endtask

    // Drops v_sync and watches 80 cycles for the report
    task automatic finish_frame(output int first_cv, output bit saw_busy);
        v_sync   = 1'b0;
        first_cv = 0;
        saw_busy = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (busy) saw_busy = 1'b1;
            if (center_valid && first_cv == 0) first_cv = i;
        end
    endtask

    initial begin
        reset = 1'b1; video_in = 24'h0; h_sync = 1'b0; v_sync = 1'b0;
        mode = 2'd1; threshold = 8'd128; min_count = 19'd1;
        overlay_en = 1'b0; vid_select = 1'b0;
        tick(); tick();
        check_eq("rst_video", video_out, 24'h0);
        check_eq("rst_de", de_out, 1'b0);
        check_eq("rst_cx", center_x, 10'd0);
        check_eq("rst_cy", center_y, 9'd0);
        check_eq("rst_obj", obj_present, 1'b0);
        check_eq("rst_cv", center_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        // Red 4x4 block with non-dominant and sub-threshold distractors
        c0 = cv_total;
        run_frame(0, 0);
        check_eq("a1_pass_blob", out_mem[51][101], 24'hC81414);
        check_eq("a1_pass_other", out_mem[10][10], 24'hC8C800);
        finish_frame(lat, busy_seen);
        check_eq("a1_latency_ok", (lat >= 1 && lat <= LAT_MAX), 1'b1);
        check_eq("a1_busy_seen", busy_seen, 1'b1);
        check_eq("a1_cx", center_x, 10'd101);
        check_eq("a1_cy", center_y, 9'd51);
        check_eq("a1_obj", obj_present, 1'b1);
        check_eq("a1_pulses", cv_total - c0, 32'd1);
        check_eq("a1_busy_end", busy, 1'b0);

        // Same frame, too few hits
        min_count = 19'd17;
        c0 = cv_total;
        run_frame(0, 0);
        finish_frame(lat, busy_seen);
        check_eq("a2_latency", lat, 32'd1);
        check_eq("a2_obj", obj_present, 1'b0);
        check_eq("a2_cx_held", center_x, 10'd101);
        check_eq("a2_cy_held", center_y, 9'd51);
        check_eq("a2_no_busy", busy_seen, 1'b0);
        check_eq("a2_pulses", cv_total - c0, 32'd1);

        // Reset during the X division
        min_count = 19'd1;
        run_frame(0, 0);
        v_sync = 1'b0;
        repeat (5) tick();
        check_eq("rd_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        check_eq("rd_busy", busy, 1'b0);
        check_eq("rd_cv", center_valid, 1'b0);
        check_eq("rd_cx", center_x, 10'd0);
        check_eq("rd_obj", obj_present, 1'b0);
        check_eq("rd_video", video_out, 24'h0);
        reset = 1'b0;
        c0 = cv_total;
        repeat (80) tick();
        check_eq("rd_no_pulse", cv_total - c0, 32'd0);

        // Reset released mid-frame: no report, next frame reports
        c0 = cv_total;
        run_frame(0, 10);
        finish_frame(lat, busy_seen);
        check_eq("pf_no_pulse", cv_total - c0, 32'd0);
        run_frame(0, 0);
        finish_frame(lat, busy_seen);
        check_eq("ff_latency_ok", (lat >= 1 && lat <= LAT_MAX), 1'b1);
        check_eq("ff_cx", center_x, 10'd101);
        check_eq("ff_cy", center_y, 9'd51);
        check_eq("ff_obj", obj_present, 1'b1);

        // Single hit at origin; crosshair around previous centroid during this frame
        overlay_en = 1'b1;
        run_frame(1, 0);
        check_eq("sh_mark_xarm", out_mem[51][109], MARK);
        check_eq("sh_mark_xout", out_mem[51][110], 24'h0);
        check_eq("sh_mark_yarm", out_mem[43][101], MARK);
        check_eq("sh_mark_yout", out_mem[42][101], 24'h0);
        finish_frame(lat, busy_seen);
        check_eq("sh_cx", center_x, 10'd0);
        check_eq("sh_cy", center_y, 9'd0);
        check_eq("sh_obj", obj_present, 1'b1);

        // Black frame showing the crosshair clipped at the origin
        run_frame(2, 0);
        check_eq("ov_00", out_mem[0][0], MARK);
        check_eq("ov_x8", out_mem[0][8], MARK);
        check_eq("ov_y8", out_mem[8][0], MARK);
        check_eq("ov_x9", out_mem[0][9], 24'h0);
        check_eq("ov_y9", out_mem[9][0], 24'h0);
        check_eq("ov_nowrap_x", out_mem[0][H-1], 24'h0);
        check_eq("ov_nowrap_y", out_mem[V-1][0], 24'h0);
        check_eq("ov_diag", out_mem[1][1], 24'h0);
        finish_frame(lat, busy_seen);
        check_eq("ov_obj", obj_present, 1'b0);
        check_eq("ov_cx_held", center_x, 10'd0);

        // Luma mode, bright corner pixel, binary mask output
        overlay_en = 1'b0; vid_select = 1'b1; mode = 2'd0; threshold = 8'd200;
        run_frame(3, 0);
        check_eq("gy_mask_hit", out_mem[V-1][H-1], 24'hFFFFFF);
        check_eq("gy_mask_nb", out_mem[V-1][H-2], 24'h0);
        check_eq("gy_mask_dim", out_mem[5][5], 24'h0);
        check_eq("gy_mask_00", out_mem[0][0], 24'h0);
        finish_frame(lat, busy_seen);
        check_eq("gy_cx", center_x, 10'(H - 1));
        check_eq("gy_cy", center_y, 9'(V - 1));
        check_eq("gy_obj", obj_present, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
